// File: rtl/averager_frame_arbiter.sv
// Frame-granular round-robin arbiter that shares one ensemble averager input
// between NCH sample sources. A granted channel keeps the port for FRAME accepted samples.
module averager_frame_arbiter #(
  parameter int W     = 24,
  parameter int NCH   = 4,
  parameter int FRAME = 1024,
  parameter int CW    = 10,
  parameter int IDW   = 2
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [NCH*W-1:0] In_data,
  input  logic [NCH-1:0]   In_valid,
  output logic [NCH-1:0]   In_ready,
  output logic [W-1:0]     Out_data,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [IDW-1:0]   Gnt_id,
  output logic             Busy,
  output logic             Frame_done,
  output logic [15:0]      Frame_cnt
);

  typedef enum logic [1:0] {ARB, XFER, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  cnt;
  logic [IDW-1:0] last, start, winner;
  logic [NCH-1:0] req_rot;
  logic           hit, handshake, last_beat;

  // Rotate the requests so the channel after the last owner sits at bit 0.
  always_comb begin
    start   = (last == IDW'(NCH - 1)) ? '0 : last + 1'b1;
    req_rot = NCH'({In_valid, In_valid} >> start);
    hit     = 1'b0;
    winner  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!hit && req_rot[i]) begin
        hit    = 1'b1;
        winner = IDW'((int'(start) + i) % NCH);
      end
    end
  end

  always_comb begin
    Out_data  = '0;
    Out_valid = 1'b0;
    In_ready  = '0;
    if (state == XFER) begin
      Out_data  = W'(In_data >> (Gnt_id * W));
      Out_valid = |(In_valid & (NCH'(1) << Gnt_id));
      In_ready  = Out_ready ? (NCH'(1) << Gnt_id) : '0;
    end
  end

  assign handshake = Out_valid & Out_ready;
  assign last_beat = (cnt == CW'(FRAME - 1));

  always_comb begin
    state_nxt  = state;
    Frame_done = 1'b0;
    case (state)
      ARB:  if (hit) state_nxt = XFER;
      XFER: if (handshake && last_beat) state_nxt = DONE;
      DONE: begin
        Frame_done = 1'b1;
        state_nxt  = ARB;
      end
      default: state_nxt = ARB;
    endcase
  end

  // A synchronous reset mid-frame simply discards the partial frame.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state     <= ARB;
      cnt       <= '0;
      last      <= IDW'(NCH - 1);
      Gnt_id    <= '0;
      Busy      <= 1'b0;
      Frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ARB: if (hit) begin
          Gnt_id <= winner;
          Busy   <= 1'b1;
          cnt    <= '0;
        end
        XFER: if (handshake) cnt <= last_beat ? '0 : cnt + 1'b1;
        DONE: begin
          Frame_cnt <= Frame_cnt + 1'b1;
          last      <= Gnt_id;
          Busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_averager_frame_arbiter.sv
// Bench for averager_frame_arbiter: a per-cycle vector table for one frame, a
// scoreboard of expected samples, and hand-built round-robin/backpressure/stall/reset/idle sequences.
module tb_averager_frame_arbiter;
  localparam int W     = 24;
  localparam int NCH   = 4;
  localparam int FRAME = 8;
  localparam int CW    = 3;
  localparam int IDW   = 2;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [NCH*W-1:0] In_data;
  logic [NCH-1:0]   In_valid;
  logic [NCH-1:0]   In_ready;
  logic [W-1:0]     Out_data;
  logic             Out_valid;
  logic             Out_ready;
  logic [IDW-1:0]   Gnt_id;
  logic             Busy;
  logic             Frame_done;
  logic [15:0]      Frame_cnt;

  averager_frame_arbiter #(.W(W), .NCH(NCH), .FRAME(FRAME), .CW(CW), .IDW(IDW)) dut (
    .Clk(Clk), .Rst(Rst), .In_data(In_data), .In_valid(In_valid), .In_ready(In_ready),
    .Out_data(Out_data), .Out_valid(Out_valid), .Out_ready(Out_ready), .Gnt_id(Gnt_id),
    .Busy(Busy), .Frame_done(Frame_done), .Frame_cnt(Frame_cnt)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [IDW-1:0] ch;
    logic [W-1:0]   data;
  } sb_t;

  typedef struct {
    logic [NCH-1:0] valid;
    logic           ready;
    logic [NCH-1:0] exp_ready;
    logic           exp_ovalid;
    logic [IDW-1:0] exp_gnt;
    logic           exp_busy;
    logic           exp_done;
    logic [15:0]    exp_fcnt;
  } vec_t;

  sb_t  sb[$];
  vec_t vecs[12];
  int   checks = 0;
  int   errors = 0;
  int   sidx[NCH];
  int   hs_count = 0;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_frame(input int ch, input int first_idx);
    sb_t e;
    for (int i = 0; i < FRAME; i++) begin
      e.ch   = IDW'(ch);
      e.data = W'(ch * 16 + first_idx + i);
      sb.push_back(e);
    end
  endtask

  // Drives one cycle at the falling edge, then scores any handshake it sees.
  task automatic apply_stimulus(input logic rst, input logic [NCH-1:0] valid, input logic ready);
    sb_t e;
    @(negedge Clk);
    Rst       = rst;
    In_valid  = valid;
    Out_ready = ready;
    for (int k = 0; k < NCH; k++) In_data[k*W +: W] = W'(k * 16 + sidx[k]);
    #1;
    if (rst && Out_valid && Out_ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        check_output("sb_unexpected_handshake", 1, 0);
      end else begin
        e = sb.pop_front();
        check_output("sb_data", int'(Out_data), int'(e.data));
        check_output("sb_gnt", int'(Gnt_id), int'(e.ch));
        check_output("sb_in_ready", int'(In_ready), int'(NCH'(1) << e.ch));
      end
    end
    for (int k = 0; k < NCH; k++)
      if (rst && In_valid[k] && In_ready[k]) sidx[k]++;
  endtask

  task automatic do_reset();
    apply_stimulus(1'b0, '0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0);
    for (int k = 0; k < NCH; k++) sidx[k] = 0;
  endtask

  initial begin
    int t, hs0, ndone, bad;
    Rst = 1'b0; In_valid = '0; In_data = '0; Out_ready = 1'b0;
    for (int k = 0; k < NCH; k++) sidx[k] = 0;

    for (int r = 0; r < 12; r++) begin
      vecs[r] = '{valid: 4'b0100, ready: 1'b1, exp_ready: 4'b0000, exp_ovalid: 1'b0,
                  exp_gnt: 2'd2, exp_busy: 1'b0, exp_done: 1'b0, exp_fcnt: 16'd0};
      if (r == 0) vecs[r].exp_gnt = 2'd0;
      if (r >= 1 && r <= 8) begin
        vecs[r].exp_ready  = 4'b0100;
        vecs[r].exp_ovalid = 1'b1;
        vecs[r].exp_busy   = 1'b1;
      end
      if (r == 9) begin
        vecs[r].exp_busy = 1'b1;
        vecs[r].exp_done = 1'b1;
      end
      if (r >= 10) begin
        vecs[r].valid    = 4'b0000;
        vecs[r].exp_fcnt = 16'd1;
      end
    end

    do_reset();
    check_output("rst_gnt", int'(Gnt_id), 0);
    check_output("rst_busy", int'(Busy), 0);
    check_output("rst_done", int'(Frame_done), 0);
    check_output("rst_fcnt", int'(Frame_cnt), 0);
    check_output("rst_in_ready", int'(In_ready), 0);
    check_output("rst_out_valid", int'(Out_valid), 0);
    check_output("rst_out_data", int'(Out_data), 0);

    $display("[TB] single channel table");
    push_frame(2, 0);
    for (int r = 0; r < 12; r++) begin
      apply_stimulus(1'b1, vecs[r].valid, vecs[r].ready);
      check_output($sformatf("vec%0d_in_ready", r), int'(In_ready), int'(vecs[r].exp_ready));
      check_output($sformatf("vec%0d_out_valid", r), int'(Out_valid), int'(vecs[r].exp_ovalid));
      check_output($sformatf("vec%0d_gnt", r), int'(Gnt_id), int'(vecs[r].exp_gnt));
      check_output($sformatf("vec%0d_busy", r), int'(Busy), int'(vecs[r].exp_busy));
      check_output($sformatf("vec%0d_done", r), int'(Frame_done), int'(vecs[r].exp_done));
      check_output($sformatf("vec%0d_fcnt", r), int'(Frame_cnt), int'(vecs[r].exp_fcnt));
      if (!vecs[r].exp_ovalid)
        check_output($sformatf("vec%0d_out_data_idle", r), int'(Out_data), 0);
    end
    check_output("single_sb_empty", sb.size(), 0);

    $display("[TB] round robin");
    do_reset();
    for (int f = 0; f < 5; f++) push_frame(f % NCH, (f / NCH) * FRAME);
    t = 0; ndone = 0;
    while (ndone < 5 && t < 80) begin
      apply_stimulus(1'b1, '1, 1'b1);
      if (Frame_done) begin
        check_output($sformatf("rr_gnt_frame%0d", ndone), int'(Gnt_id), ndone % NCH);
        check_output($sformatf("rr_done_cycle%0d", ndone), t, 10 * ndone + 9);
        ndone++;
      end
      t++;
    end
    check_output("rr_frames", ndone, 5);
    apply_stimulus(1'b1, '0, 1'b1);
    check_output("rr_fcnt", int'(Frame_cnt), 5);
    check_output("rr_sb_empty", sb.size(), 0);

    $display("[TB] backpressure");
    do_reset();
    push_frame(3, 0);
    hs0 = hs_count;
    apply_stimulus(1'b1, 4'b1000, 1'b0);
    t = 1;
    while (!Frame_done && t < 40) begin
      apply_stimulus(1'b1, 4'b1000, (t % 2) == 1);
      if (!Frame_done) t++;
    end
    check_output("bp_done_cycle", t, 16);
    check_output("bp_handshakes", hs_count - hs0, FRAME);
    apply_stimulus(1'b1, '0, 1'b1);
    check_output("bp_fcnt", int'(Frame_cnt), 1);

    $display("[TB] source stall");
    do_reset();
    push_frame(1, 0);
    apply_stimulus(1'b1, 4'b0010, 1'b1);
    for (int c = 1; c <= 3; c++) apply_stimulus(1'b1, 4'b1011, 1'b1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      apply_stimulus(1'b1, 4'b1001, 1'b1);
      if (Out_valid || In_ready != 4'b0010 || Gnt_id != 2'd1 || !Busy || Frame_done) bad++;
    end
    check_output("stall_hold_bad_cycles", bad, 0);
    t = 24;
    while (t < 45) begin
      apply_stimulus(1'b1, 4'b1011, 1'b1);
      if (Frame_done) break;
      t++;
    end
    check_output("stall_done_cycle", t, 29);
    check_output("stall_sb_empty", sb.size(), 0);
    apply_stimulus(1'b1, 4'b1001, 1'b1);
    apply_stimulus(1'b0, '0, 1'b0);
    check_output("stall_next_gnt", int'(Gnt_id), 3);

    $display("[TB] reset mid-frame");
    do_reset();
    push_frame(1, 0);
    apply_stimulus(1'b1, 4'b0010, 1'b1);
    for (int c = 1; c <= 5; c++) apply_stimulus(1'b1, 4'b0011, 1'b1);
    apply_stimulus(1'b0, 4'b0011, 1'b0);
    check_output("mid_rst_done", int'(Frame_done), 0);
    while (sb.size() > 0) void'(sb.pop_front());
    push_frame(0, 0);
    apply_stimulus(1'b1, 4'b0011, 1'b1);
    check_output("mid_in_ready", int'(In_ready), 0);
    check_output("mid_busy", int'(Busy), 0);
    check_output("mid_fcnt", int'(Frame_cnt), 0);
    check_output("mid_done", int'(Frame_done), 0);
    check_output("mid_gnt", int'(Gnt_id), 0);
    t = 8; ndone = 0;
    while (t < 30) begin
      apply_stimulus(1'b1, 4'b0011, 1'b1);
      if (Frame_done) break;
      t++;
    end
    check_output("mid_done_cycle", t, 16);
    check_output("mid_sb_empty", sb.size(), 0);
    apply_stimulus(1'b1, '0, 1'b1);
    check_output("mid_fcnt_after", int'(Frame_cnt), 1);

    $display("[TB] idle");
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      apply_stimulus(1'b1, '0, 1'b1);
      if (Out_valid || In_ready != '0 || Busy || Frame_done || Frame_cnt != 16'd1 || Out_data != '0) bad++;
    end
    check_output("idle_bad_cycles", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/averager_frame_arbiter.md
Name: averager_frame_arbiter

Overview:
- Shares one ensemble averager between NCH independent frame sources. Arbitration is frame-granular round-robin.
- Once a channel is granted, it owns the averager input for exactly FRAME accepted samples. Only then can the grant move.
- Sits between the per-channel front ends (FFT/polyphase outputs) and the averager's Valid_in/Ready_in port.
- Reports which channel owns each frame so downstream logic can tag the averaged result.

Parameters:
- W, 24, sample width in bits (WI+WF of the averager input).
- NCH, 4, number of requesting channels (2..8).
- FRAME, 1024, samples per frame (the averager winS).
- CW, 10, frame counter width; must satisfy 2^CW >= FRAME.
- IDW, 2, channel-ID width; must satisfy 2^IDW >= NCH.

Ports:
- Clk  in  1  clock
- Rst  in  1  reset, synchronous, active-low
- In_data  in  NCH*W  channel samples; channel k occupies bits [k*W +: W]
- In_valid  in  NCH  per-channel valid
- In_ready  out  NCH  per-channel ready
- Out_data  out  W  sample to averager
- Out_valid  out  1  to averager Valid_in
- Out_ready  in  1  from averager Ready_in
- Gnt_id  out  IDW  currently or last granted channel
- Busy  out  1  high while a frame transfer is in progress
- Frame_done  out  1  one-cycle pulse after the last sample of a frame is accepted
- Frame_cnt  out  16  total completed frames, wraps at 2^16

Behaviour:
- Reset is synchronous, active-low on Rst, clock Clk. On reset:
  - state=ARB, cnt=0, last=NCH-1, Gnt_id=0, Busy=0, Frame_done=0, Frame_cnt=0.
  - In_ready=0, Out_valid=0, Out_data=0.
- Reset asserted mid-frame aborts the frame. The partial frame is not counted and no Frame_done pulse is produced.
- State machine:
  - ARB:
    - Search In_valid starting at channel (last+1) mod NCH, ascending with wrap. The first set bit wins.
    - On a hit: Gnt_id<=winner, Busy<=1, cnt<=0, go to XFER.
    - No requester: stay in ARB, all In_ready=0.
    - The ARB decision takes one cycle. No data moves in ARB.
  - XFER:
    - Combinational routing: Out_data=In_data[Gnt_id], Out_valid=In_valid[Gnt_id], In_ready[Gnt_id]=Out_ready. All other In_ready bits are 0.
    - A handshake is Out_valid & Out_ready in the same cycle.
    - Each handshake increments cnt.
    - A handshake with cnt==FRAME-1 goes to DONE.
    - The granted channel dropping valid mid-frame does not release the grant. The arbiter waits indefinitely.
  - DONE:
    - Frame_done=1 for this single cycle. Frame_cnt increments; last<=Gnt_id; Busy<=0.
    - Out_valid=0 and all In_ready=0. Next state is ARB.
- Throughput: minimum gap between frames is 2 idle cycles (DONE + ARB). At full rate, one frame takes FRAME+2 cycles.
- Fairness: with all channels requesting continuously, grants cycle 0,1,...,NCH-1,0,... Starting from reset, channel 0 is served first.
- Out_data outside XFER is 0. Gnt_id holds its last value outside XFER.
- cnt never exceeds FRAME-1. FRAME=1 is legal: each grant transfers exactly one sample.
- A new request arriving in the same cycle as DONE is seen in the following ARB cycle.

Test Plan:
- Single channel (FRAME=8, NCH=4): ch2 valid constantly, Out_ready=1 -> ARB 1 cycle, then 8 handshakes with Gnt_id=2. Frame_done pulses once on the cycle after the 8th. Frame_cnt=1. In_ready[0,1,3] stay 0 throughout.
- Round-robin: all four channels valid continuously for 5 frames -> Gnt_id sequence 0,1,2,3,0. Each frame spans 10 cycles. Frame_cnt=5.
- Backpressure: Out_ready toggles 1,0 every cycle -> exactly 8 handshakes per frame. Data order is preserved, values In_data=k*16+i. Frame completes in 15 cycles after ARB.
- Source stall: granted ch1 drops valid after sample 3 for 20 cycles while ch0 and ch3 request -> grant stays on 1, no other In_ready rises. Frame finishes with sample 8 of ch1.
- Reset mid-frame: Rst=0 for 1 cycle after sample 5 -> next cycle In_ready=0, Busy=0, Frame_cnt=0, no Frame_done. With ch0 and ch1 both valid, the next frame goes to ch0 and starts at cnt=0.
- Idle: no In_valid for 50 cycles -> state stays ARB, Out_valid=0, Frame_cnt unchanged.
